// File: rtl/aes_encrypt_scheduler.sv
// Front-end scheduler for a fixed-latency, fully pipelined AES-128 encrypt core.
// Two requesters are arbitrated round-robin. Blocks in flight through the core
// are tracked by a valid/ID shift register. Core results are captured into a
// circular result FIFO that has a registered head. Issue is gated by a credit
// count (in-flight + buffered), so the FIFO never overflows even though the
// core itself can never stall.
module aes_encrypt_scheduler #(
    parameter int N          = 128,
    parameter int CORE_LAT   = 3,
    parameter int FIFO_DEPTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_pt,
    input  logic [N-1:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_pt,
    input  logic [N-1:0] req1_key,
    output logic [N-1:0] core_in,
    output logic [N-1:0] core_key,
    input  logic [N-1:0] core_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         busy
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Control state
    logic                r_rr_last;
    logic [CNT_W-1:0]    r_inflight_cnt;
    logic [CNT_W-1:0]    r_fifo_cnt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CORE_LAT-1:0] r_pipe_v;
    logic [CORE_LAT-1:0] r_pipe_id;
    logic                r_busy;
    logic [N-1:0]        r_head_data;
    logic                r_head_id;

    // FIFO storage (data only, never reset)
    logic [N-1:0]        r_mem_data [FIFO_DEPTH];
    logic                r_mem_id   [FIFO_DEPTH];

    // Combinational
    logic [CNT_W:0]      w_credit_sum;
    logic                w_can_issue;
    logic                w_grant_vld;
    logic                w_grant_id;
    logic                w_hs;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_inflight_nxt;
    logic [CNT_W-1:0]    w_fifo_cnt_nxt;
    logic [PTR_W-1:0]    w_wr_ptr_nxt;
    logic [PTR_W-1:0]    w_rd_ptr_nxt;
    logic [N-1:0]        w_head_data_nxt;
    logic                w_head_id_nxt;

    // Circular pointer increment, wrapping at FIFO_DEPTH-1
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Up/down counter step; simultaneous inc and dec cancel out
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && !dec)
            r = c + CNT_ONE;
        else if (!inc && dec)
            r = c - CNT_ONE;
        return r;
    endfunction

    assign w_credit_sum = {1'b0, r_inflight_cnt} + {1'b0, r_fifo_cnt};
    // Registered counts only, so ready has no path from res_ready; held off during reset
    assign w_can_issue  = !rst && (w_credit_sum < DEPTH_EXT);

    // Round-robin grant: with both valid, pick the requester not served last
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (w_can_issue) begin
            if (req0_valid && req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_rr_last;
            end else if (req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = w_grant_vld & ~w_grant_id;
    assign req1_ready = w_grant_vld &  w_grant_id;
    assign w_hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Core inputs follow the granted requester; zero when nothing issues
    always_comb begin
        core_in  = '0;
        core_key = '0;
        if (w_hs) begin
            core_in  = w_grant_id ? req1_pt  : req0_pt;
            core_key = w_grant_id ? req1_key : req0_key;
        end
    end

    assign w_push = r_pipe_v[CORE_LAT-1];
    assign w_pop  = (r_fifo_cnt != '0) && res_ready;

    // Next counts and pointers
    always_comb begin
        w_inflight_nxt = cnt_step(r_inflight_cnt, w_hs, w_push);
        w_fifo_cnt_nxt = cnt_step(r_fifo_cnt, w_push, w_pop);
        w_wr_ptr_nxt   = w_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
        w_rd_ptr_nxt   = w_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    end

    // Next FIFO head: new push goes straight to the head register when the FIFO drains to empty
    always_comb begin
        w_head_data_nxt = '0;
        w_head_id_nxt   = 1'b0;
        if (w_fifo_cnt_nxt != '0) begin
            if ((r_fifo_cnt == '0) || (w_pop && (r_fifo_cnt == CNT_ONE))) begin
                w_head_data_nxt = core_out;
                w_head_id_nxt   = r_pipe_id[CORE_LAT-1];
            end else begin
                w_head_data_nxt = r_mem_data[w_rd_ptr_nxt];
                w_head_id_nxt   = r_mem_id[w_rd_ptr_nxt];
            end
        end
    end

    // Control registers, tracking pipe and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last      <= 1'b1;
            r_inflight_cnt <= '0;
            r_fifo_cnt     <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_pipe_v       <= '0;
            r_pipe_id      <= '0;
            r_busy         <= 1'b0;
            r_head_data    <= '0;
            r_head_id      <= 1'b0;
        end else begin
            if (w_hs)
                r_rr_last <= w_grant_id;
            r_inflight_cnt <= w_inflight_nxt;
            r_fifo_cnt     <= w_fifo_cnt_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_pipe_v[0]    <= w_hs;
            r_pipe_id[0]   <= w_grant_id;
            for (int i = 1; i < CORE_LAT; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
            r_busy         <= (w_inflight_nxt != '0) || (w_fifo_cnt_nxt != '0);
            r_head_data    <= w_head_data_nxt;
            r_head_id      <= w_head_id_nxt;
        end
    end

    // FIFO storage write on push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= core_out;
            r_mem_id[r_wr_ptr]   <= r_pipe_id[CORE_LAT-1];
        end
    end

    assign res_valid = (r_fifo_cnt != '0);
    assign res_data  = r_head_data;
    assign res_id    = r_head_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_encrypt_scheduler.sv
// Bench for aes_encrypt_scheduler: behavioural AES-128 core with fixed latency,
// a queue-based reference model checked every cycle, and directed scenarios.
module tb_aes_encrypt_scheduler;

    localparam int N        = 128;
    localparam int CORE_LAT = 3;
    localparam int DEPTH    = 5;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R2   = 128'h3925841d02dc09fbdc118597196a0b32;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
    logic [N-1:0] req0_pt = '0, req0_key = '0, req1_pt = '0, req1_key = '0;
    logic req0_ready, req1_ready, res_valid, res_id, busy;
    logic [N-1:0] core_in, core_key, core_out, res_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    aes_encrypt_scheduler #(.N(N), .CORE_LAT(CORE_LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pt(req0_pt), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pt(req1_pt), .req1_key(req1_key),
        .core_in(core_in), .core_key(core_key), .core_out(core_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]) ^ rc, sb(t[15:8]), sb(t[7:0]), sb(t[31:24])};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb(s[i]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) u[c * 4 + q] = s[((c + q) % 4) * 4 + q];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (r != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Stand-in encrypt core: CORE_LAT rising edges from sampling to output
    logic [N-1:0] core_pipe [CORE_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CORE_LAT; i++) core_pipe[i] <= '0;
        end else begin
            core_pipe[0] <= aes128(core_key, core_in);
            for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign core_out = core_pipe[CORE_LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [127:0] data;
        bit           id;
        int           avail;
    } item_t;

    item_t mq[$];
    bit    m_rr_last = 1'b1;

    always @(negedge clk) begin : model
        bit gv, gid, ev;
        logic [127:0] ein, ekey;
        int fcnt;
        item_t it;
        if (rst) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_busy", busy, 0);
            chk("rst_core_in", core_in, 0);
            chk("rst_core_key", core_key, 0);
            mq.delete();
            m_rr_last = 1'b1;
        end else begin
            gv = 1'b0; gid = 1'b0;
            if (mq.size() < DEPTH) begin
                if (req0_valid && req1_valid) begin gv = 1'b1; gid = !m_rr_last; end
                else if (req0_valid) begin gv = 1'b1; gid = 1'b0; end
                else if (req1_valid) begin gv = 1'b1; gid = 1'b1; end
            end
            chk("req0_ready", req0_ready, gv && !gid);
            chk("req1_ready", req1_ready, gv && gid);
            ein  = gv ? (gid ? req1_pt  : req0_pt)  : '0;
            ekey = gv ? (gid ? req1_key : req0_key) : '0;
            chk("core_in", core_in, ein);
            chk("core_key", core_key, ekey);
            ev = (mq.size() > 0) && (mq[0].avail <= cyc);
            chk("res_valid", res_valid, ev);
            if (ev) begin
                chk("res_data", res_data, mq[0].data);
                chk("res_id", res_id, mq[0].id);
            end
            chk("busy", busy, mq.size() != 0);
            fcnt = 0;
            foreach (mq[k]) if (mq[k].avail <= cyc) fcnt++;
            chk("fifo_cnt", dut.r_fifo_cnt, fcnt);
            if (dut.r_pipe_v[CORE_LAT-1])
                chk("push_not_full", dut.r_fifo_cnt < 3'(DEPTH), 1);
            if (ev && res_ready) void'(mq.pop_front());
            if (gv) begin
                it.data  = gid ? aes128(req1_key, req1_pt) : aes128(req0_key, req0_pt);
                it.id    = gid;
                it.avail = cyc + CORE_LAT + 1;
                mq.push_back(it);
                m_rr_last = gid;
            end
        end
    end

    // ---------------- transaction log for directed checks ----------------
    bit           hs_id[$];
    int           hs_cyc[$];
    logic [127:0] got_data[$];
    bit           got_id[$];
    int           got_cyc[$];
    int           run = 0, max_run = 0, wrap_pp = 0;

    always @(negedge clk) begin : monitor
        if (!rst) begin
            if (req0_valid && req0_ready) begin hs_id.push_back(1'b0); hs_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin hs_id.push_back(1'b1); hs_cyc.push_back(cyc); end
            if (res_valid && res_ready) begin
                got_data.push_back(res_data); got_id.push_back(res_id); got_cyc.push_back(cyc);
                if (dut.r_pipe_v[CORE_LAT-1] &&
                    (dut.r_rd_ptr == 3'(DEPTH - 1) || dut.r_wr_ptr == 3'(DEPTH - 1)))
                    wrap_pp++;
            end
            run = res_valid ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end

    // ---------------- stimulus ----------------
    int seq0 = 0, seq1 = 0;

    task automatic clear_logs();
        hs_id.delete(); hs_cyc.delete(); got_data.delete(); got_id.delete(); got_cyc.delete();
        run = 0; max_run = 0; wrap_pp = 0; seq0 = 0; seq1 = 0;
    endtask

    // Drive for ncyc cycles; with vary set, each requester's pt advances on every handshake
    task automatic drive_stream(input int ncyc, input bit v0, input bit v1, input bit rr, input bit vary);
        for (int c = 0; c < ncyc; c++) begin
            req0_valid = v0; req1_valid = v1; res_ready = rr;
            req0_key = K1; req1_key = K2;
            req0_pt = vary ? (P1 ^ 128'(seq0)) : P1;
            req1_pt = vary ? (P2 ^ 128'(seq1)) : P2;
            @(negedge clk);
            if (req0_valid && req0_ready) seq0++;
            if (req1_valid && req1_ready) seq1++;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        res_ready = 1'b1;
        while (busy && n < lim) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // pin the reference core with known-answer vectors
        chk("kat_fips_c1", aes128(K1, P1), R1);
        chk("kat_fips_b", aes128(K2, P2), R2);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready0", req0_ready, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;

        // 1: single block, latency and data
        clear_logs();
        drive_stream(1, 1, 0, 1, 0);
        wait_idle(40);
        chk("t1_hs_count", hs_id.size(), 1);
        chk("t1_res_count", got_data.size(), 1);
        if (got_data.size() > 0 && hs_cyc.size() > 0) begin
            chk("t1_data", got_data[0], R1);
            chk("t1_id", got_id[0], 0);
            chk("t1_latency", got_cyc[0] - hs_cyc[0], 4);
        end

        // 2: both requesters valid for 4 cycles, alternating grants
        pulse_reset();
        clear_logs();
        drive_stream(4, 1, 1, 1, 0);
        wait_idle(40);
        chk("t2_hs_count", hs_id.size(), 4);
        chk("t2_res_count", got_data.size(), 4);
        for (int i = 0; i < 4 && i < hs_id.size() && i < got_data.size(); i++) begin
            chk("t2_grant", hs_id[i], i % 2);
            chk("t2_res_id", got_id[i], i % 2);
            chk("t2_res_data", got_data[i], (i % 2) ? R2 : R1);
        end

        // 3: back-pressure fills credit, then drain and resume
        clear_logs();
        drive_stream(10, 1, 0, 0, 1);
        chk("t3_hs_stalled", hs_id.size(), 5);
        drive_stream(8, 1, 0, 1, 1);
        wait_idle(60);
        chk("t3_resumed", hs_id.size() > 5, 1);
        chk("t3_count_match", got_data.size(), hs_id.size());
        for (int i = 0; i < got_data.size(); i++)
            chk("t3_order", got_data[i], aes128(K1, P1 ^ 128'(i)));

        // 4: 20 back-to-back blocks at full throughput
        clear_logs();
        drive_stream(20, 1, 0, 1, 1);
        chk("t4_hs_count", hs_id.size(), 20);
        wait_idle(60);
        chk("t4_res_count", got_data.size(), 20);
        chk("t4_valid_run", max_run, 20);

        // 5: reset with 2 blocks in flight and 2 in the FIFO
        clear_logs();
        drive_stream(4, 1, 0, 0, 1);
        @(posedge clk); #1;
        chk("t5_pre_fifo_cnt", dut.r_fifo_cnt, 2);
        chk("t5_pre_inflight", dut.r_inflight_cnt, 2);
        req0_valid = 1'b1; req0_pt = P1; req0_key = K1;
        rst = 1'b1;
        #1;
        chk("t5_ready0", req0_ready, 0);
        chk("t5_res_valid", res_valid, 0);
        chk("t5_res_data", res_data, 0);
        chk("t5_res_id", res_id, 0);
        chk("t5_busy", busy, 0);
        chk("t5_core_in", core_in, 0);
        chk("t5_core_key", core_key, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        drive_stream(8, 0, 0, 1, 0);
        chk("t5_no_stale", got_data.size(), 0);
        drive_stream(1, 1, 0, 1, 0);
        wait_idle(40);
        chk("t5_after_count", got_data.size(), 1);
        if (got_data.size() > 0) chk("t5_after_data", got_data[0], R1);

        // 6: simultaneous push/pop across the pointer wrap
        clear_logs();
        drive_stream(3, 1, 0, 0, 1);
        drive_stream(12, 1, 0, 1, 1);
        wait_idle(60);
        chk("t6_count_match", got_data.size(), hs_id.size());
        for (int i = 0; i < got_data.size(); i++)
            chk("t6_order", got_data[i], aes128(K1, P1 ^ 128'(i)));
        chk("t6_wrap_pushpop", wrap_pp > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
